// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared defines for the divide controller: divider handshake levels and FSM states
package div_ctrl_pkg;

   localparam logic DIV_START = 1'b1;
   localparam logic DIV_STOP  = 1'b0;
   localparam logic ENABLE    = 1'b1;
   localparam logic DISABLE   = 1'b0;

   localparam int WD_W = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - EX-stage controller sequencing a multi-cycle divider and capturing HI/LO
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        div_req_i,
   input  logic        div_signed_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic        flush_i,
   input  logic [63:0] div_result_i,
   input  logic        div_ready_i,
   output logic [31:0] div_opdata1_o,
   output logic [31:0] div_opdata2_o,
   output logic        div_signed_o,
   output logic        div_start_o,
   output logic        div_annul_o,
   output logic        stallreq_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        whilo_o,
   output logic        timeout_o
);

   div_state_t      state;
   logic [WD_W-1:0] wd_cnt;
   logic [31:0]     op1;
   logic [31:0]     op2;
   logic            op_signed;
   logic            in_idle;
   logic            in_wait;
   logic            accept;
   logic            wd_expire;

   assign in_idle = (state == ST_IDLE);
   assign in_wait = (state == ST_WAIT);
   assign accept  = in_idle & div_req_i & ~flush_i;

   // Ready in the last permitted cycle still wins over the watchdog; flush wins over both.
   assign wd_expire = in_wait & ~flush_i & ~div_ready_i
                    & (wd_cnt == WD_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         wd_cnt    <= '0;
         op1       <= '0;
         op2       <= '0;
         op_signed <= 1'b0;
         hi_o      <= '0;
         lo_o      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op1       <= reg1_i;
                  op2       <= reg2_i;
                  op_signed <= div_signed_i;
                  wd_cnt    <= '0;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (flush_i) begin
                  state <= ST_IDLE;
               end else if (div_ready_i) begin
                  hi_o  <= div_result_i[63:32];
                  lo_o  <= div_result_i[31:0];
                  state <= ST_DONE;
               end else if (wd_expire) begin
                  state <= ST_IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign div_opdata1_o = op1;
   assign div_opdata2_o = op2;
   assign div_signed_o  = op_signed;
   assign div_start_o   = in_wait ? DIV_START : DIV_STOP;
   assign div_annul_o   = in_wait & (flush_i | wd_expire);
   assign timeout_o     = wd_expire;
   assign whilo_o       = (state == ST_DONE) ? ENABLE : DISABLE;

   // The request cycle stalls too, but nothing may be requested while reset is held.
   assign stallreq_o    = ~rst & (accept | in_wait);

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - scoreboard bench for div_ctrl with a behavioural divider and random stimulus
module tb_div_ctrl;

   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        div_req_i = 1'b0;
   logic        div_signed_i = 1'b0;
   logic [31:0] reg1_i = '0;
   logic [31:0] reg2_i = '0;
   logic        flush_i = 1'b0;
   logic [63:0] div_result_i = '0;
   logic        div_ready_i = 1'b0;
   logic [31:0] div_opdata1_o, div_opdata2_o, hi_o, lo_o;
   logic        div_signed_o, div_start_o, div_annul_o, stallreq_o, whilo_o, timeout_o;

   div_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .div_req_i(div_req_i), .div_signed_i(div_signed_i),
      .reg1_i(reg1_i), .reg2_i(reg2_i), .flush_i(flush_i),
      .div_result_i(div_result_i), .div_ready_i(div_ready_i),
      .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
      .div_signed_o(div_signed_o), .div_start_o(div_start_o),
      .div_annul_o(div_annul_o), .stallreq_o(stallreq_o),
      .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;   // 0 = HI/LO write, 1 = flushed, 2 = watchdog abort
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] a;
      logic [31:0] b;
      logic        sgn;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          ev_count = 0;
   int          model_lat = 1000;
   logic [31:0] cur_hi = '0;
   logic [31:0] cur_lo = '0;
   int          done_cyc = 0;
   bit          gap_chk = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      int sa, sb_;
      if (b == 0) return 64'd0;
      if (sgn) begin
         sa = a;
         sb_ = b;
         return {32'(sa % sb_), 32'(sa / sb_)};
      end
      return {a % b, a / b};
   endfunction

   // Behavioural divider: answers model_lat cycles after DivStart, from whatever the controller latched.
   initial begin
      int mcnt = 0;
      forever begin
         @(posedge clk); #1;
         if (rst || !div_start_o) begin
            mcnt = 0;
            div_ready_i = 1'b0;
         end else begin
            mcnt++;
            div_ready_i = (mcnt == model_lat);
            div_result_i = div_ready_i ? ref_div(div_signed_o, div_opdata1_o, div_opdata2_o)
                                       : {$urandom, $urandom};
         end
      end
   end

   // Monitor: pops the scoreboard on every write, flush abort or watchdog abort.
   initial begin
      int   stall_cnt = 0;
      int   wait_cnt = 0;
      logic prev_start = 1'b0;
      exp_t e;
      int   kind;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_cnt = 0;
            wait_cnt = 0;
            prev_start = 1'b0;
         end else begin
            if (stallreq_o) stall_cnt++;
            if (div_start_o) begin
               wait_cnt++;
               if (sb.size() == 0) chk("spurious_start", 1, 0);
               else if (div_ready_i) begin
                  chk("opdata1", div_opdata1_o, sb[0].a);
                  chk("opdata2", div_opdata2_o, sb[0].b);
                  chk("signed", div_signed_o, sb[0].sgn);
               end
               if (!prev_start && gap_chk) begin
                  chk("b2b_gap", cyc - done_cyc, 2);
                  gap_chk = 0;
               end
            end
            if (whilo_o || div_annul_o) begin
               kind = whilo_o ? 0 : (timeout_o ? 2 : 1);
               if (sb.size() == 0) chk("unexpected_event", kind + 1, 0);
               else begin
                  e = sb.pop_front();
                  chk("event_kind", kind, e.kind);
                  chk("hi", hi_o, e.hi);
                  chk("lo", lo_o, e.lo);
                  if (kind == 0) begin
                     chk("stall_cycles", stall_cnt, 1 + e.lat);
                     chk("start_in_done", div_start_o, 0);
                     done_cyc = cyc;
                  end
                  if (kind == 2) chk("timeout_cycle", wait_cnt, TO);
               end
               stall_cnt = 0;
               wait_cnt = 0;
               ev_count++;
            end
            prev_start = div_start_o;
         end
      end
   end

   // flush_at: 0 none, 1..lat flushes in that WAIT cycle, lat+1 lands in DONE.
   task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int flush_at);
      exp_t e;
      logic [63:0] r;
      int ev0, k;
      bit done;
      r = ref_div(sgn, a, b);
      e.a = a; e.b = b; e.sgn = sgn; e.lat = lat;
      if (flush_at >= 1 && flush_at <= lat && flush_at <= TO) begin
         e.kind = 1; e.hi = cur_hi; e.lo = cur_lo;
      end else if (lat > TO) begin
         e.kind = 2; e.hi = cur_hi; e.lo = cur_lo;
      end else begin
         e.kind = 0; e.hi = r[63:32]; e.lo = r[31:0];
         cur_hi = r[63:32]; cur_lo = r[31:0];
      end
      sb.push_back(e);
      model_lat = lat;
      ev0 = ev_count;
      div_req_i = 1'b1; div_signed_i = sgn; reg1_i = a; reg2_i = b;
      @(posedge clk); #1;
      div_req_i = 1'b0; div_signed_i = $urandom; reg1_i = $urandom; reg2_i = $urandom;
      k = 0;
      done = 0;
      for (int c = 0; c < 300 && !done; c++) begin
         k++;
         flush_i = (k == flush_at);
         @(posedge clk); #1;
         if (ev_count != ev0) done = 1;
      end
      flush_i = 1'b0;
      if (!done) chk("completion_timeout", 0, 1);
   endtask

   initial begin
      logic sgn;
      logic [31:0] a, b;
      int lat, fa;

      #2;
      chk("rst_stall", stallreq_o, 0);
      chk("rst_start", div_start_o, 0);
      chk("rst_hilo", {hi_o, lo_o}, 0);
      chk("rst_whilo", {whilo_o, timeout_o, div_annul_o}, 0);
      chk("rst_opdata", {div_opdata1_o, div_opdata2_o}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      do_div(0, 32'd100, 32'd7, 35, 0);
      do_div(1, 32'hFFFFFF9C, 32'd7, 20, 0);
      do_div(0, 32'd55, 32'd4, 30, 10);
      do_div(0, 32'd9, 32'd3, 12, 0);
      do_div(0, 32'd20, 32'd6, 8, 0);
      gap_chk = 1;
      do_div(0, 32'd50, 32'd5, 8, 0);
      chk("b2b_gap_seen", gap_chk, 0);

      // flush on the request cycle must suppress acceptance
      div_req_i = 1'b1; flush_i = 1'b1;
      @(negedge clk);
      chk("idle_flush_stall", stallreq_o, 0);
      chk("idle_flush_annul", div_annul_o, 0);
      @(posedge clk); #1;
      div_req_i = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      chk("idle_flush_no_start", div_start_o, 0);
      @(posedge clk); #1;

      do_div(0, 32'd1000, 32'd10, 5, 6);
      do_div(0, 32'd123, 32'd0, 7, 0);
      do_div(1, 32'd77, 32'd9, 3, 3);
      do_div(1, 32'hFFFFFFF0, 32'hFFFFFFFD, 1, 0);

      for (int i = 0; i < 30; i++) begin
         sgn = $urandom;
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'd0;
            1: b = $urandom_range(1, 20);
            2: b = -$urandom_range(1, 20);
            default: b = $urandom;
         endcase
         if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
         lat = $urandom_range(1, 50);
         fa = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lat + 1) : 0;
         do_div(sgn, a, b, lat, fa);
      end

      do_div(0, 32'd500, 32'd3, 1000, 0);
      do_div(0, 32'd17, 32'd5, 4, 0);

      // reset in the middle of a divide
      model_lat = 1000;
      div_req_i = 1'b1; div_signed_i = 1'b0; reg1_i = 32'd99; reg2_i = 32'd4;
      sb.push_back('{0, 32'd0, 32'd0, 32'd99, 32'd4, 1'b0, 1000});
      @(posedge clk); #1;
      div_req_i = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      chk("pre_rst_start", div_start_o, 1);
      rst = 1'b1;
      #1;
      chk("async_rst_start", div_start_o, 0);
      chk("async_rst_stall", stallreq_o, 0);
      chk("async_rst_hilo", {hi_o, lo_o}, 0);
      chk("async_rst_opdata", {div_opdata1_o, div_opdata2_o, 31'd0, div_signed_o}, 0);
      sb.delete();
      cur_hi = '0; cur_lo = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (80) @(posedge clk);
      #1;
      chk("post_rst_idle", {div_start_o, stallreq_o, whilo_o}, 0);
      do_div(0, 32'd40, 32'd6, 9, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: maximum WAIT cycles before abort.
REQ-002 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port div_req_i, input, 1: EX-stage instruction is DIV/DIVU.
REQ-005 SHALL have port div_signed_i, input, 1: 1 = DIV, 0 = DIVU.
REQ-006 SHALL have port reg1_i, input, 32: dividend.
REQ-007 SHALL have port reg2_i, input, 32: divisor.
REQ-008 SHALL have port flush_i, input, 1: pipeline flush; kills the in-flight divide.
REQ-009 SHALL have port div_result_i, input, 64: divider result, {remainder, quotient}.
REQ-010 SHALL have port div_ready_i, input, 1: divider result valid.
REQ-011 SHALL have port div_opdata1_o, output, 32: latched dividend to divider.
REQ-012 SHALL have port div_opdata2_o, output, 32: latched divisor to divider.
REQ-013 SHALL have port div_signed_o, output, 1: latched signedness to divider.
REQ-014 SHALL have port div_start_o, output, 1: DivStart/DivStop to divider.
REQ-015 SHALL have port div_annul_o, output, 1: cancel to divider.
REQ-016 SHALL have port stallreq_o, output, 1: pipeline stall request.
REQ-017 SHALL have ports hi_o and lo_o, output, 32 each: captured remainder and quotient.
REQ-018 SHALL have port whilo_o, output, 1: one-cycle HI/LO write enable.
REQ-019 SHALL have port timeout_o, output, 1: one-cycle watchdog abort flag.

Function
REQ-020 SHALL implement a Moore FSM with states IDLE, WAIT, DONE.
REQ-021 IDLE with div_req_i=1 and flush_i=0: SHALL latch reg1_i, reg2_i and div_signed_i at the clock edge and go to WAIT.
REQ-022 stallreq_o SHALL be combinational: (IDLE & div_req_i & ~flush_i) | WAIT, so the stall covers the request cycle.
REQ-023 div_start_o SHALL be 1 only in WAIT.
REQ-024 div_opdata*_o and div_signed_o SHALL come only from the latched registers; they stay stable throughout WAIT even if the inputs change.
REQ-025 WAIT with div_ready_i=1 and flush_i=0: SHALL load hi_o=div_result_i[63:32] and lo_o=div_result_i[31:0], then go to DONE.
REQ-026 DONE: whilo_o=1, stallreq_o=0, div_start_o=0 (DivStop releases the divider); next state SHALL be IDLE unconditionally.
REQ-027 A request present in IDLE the cycle after DONE SHALL be accepted normally (back-to-back divides); there is no dead cycle beyond DONE.
REQ-028 flush_i=1 in WAIT: div_annul_o=1 combinationally that cycle, go to IDLE; no HI/LO write, and flush SHALL take priority over a simultaneous div_ready_i.
REQ-029 flush_i=1 in IDLE: SHALL suppress acceptance; div_annul_o SHALL be 0 outside WAIT.
REQ-030 flush_i=1 in DONE: SHALL NOT cancel whilo_o, because the instruction has already committed.
REQ-031 A 7-bit watchdog counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-032 If the watchdog reaches TIMEOUT without ready: timeout_o=1 and div_annul_o=1 for that cycle, then go to IDLE with no HI/LO write.
REQ-033 A divisor of zero SHALL need no special handling: the divider returns zero and the controller writes HI=0, LO=0.
REQ-034 div_signed_o SHALL reflect the latched signedness; sign correction is the divider's job.

Reset
REQ-035 rst=1 SHALL immediately force IDLE, zero the watchdog, zero the latched operands, and zero hi_o and lo_o.
REQ-036 During reset, all outputs SHALL be 0 (stallreq_o=0, div_start_o=0).
REQ-037 Reset mid-WAIT SHALL drop div_start_o, and the controller SHALL issue no further request until a new div_req_i.

Structure
REQ-038 DivStart/DivStop, Enable/Disable and the FSM state encodings SHALL live in the shared defines package.
REQ-039 There SHALL be no sub-module; the divider is instantiated beside div_ctrl in the EX-stage parent.

Verification
REQ-040 DIVU 100/7, bench divider model asserts ready 35 cycles after start -> one whilo_o pulse, hi_o=2, lo_o=14, stallreq_o high from the request cycle through the ready cycle.
REQ-041 DIV 0xFFFFFF9C (-100)/7 -> div_signed_o=1, and the bench reflects the model result: hi_o=0xFFFFFFFE, lo_o=0xFFFFFFF2.
REQ-042 flush_i pulse 10 cycles into WAIT -> div_annul_o=1 that cycle, no whilo_o, IDLE next cycle; a following DIVU 9/3 yields hi_o=0, lo_o=3.
REQ-043 Model never asserts ready, TIMEOUT=64 -> timeout_o pulse in WAIT cycle 64, return to IDLE, hi_o/lo_o unchanged.
REQ-044 Two back-to-back DIVU (20/6 then 50/5) -> second start rises exactly two cycles after the first DONE; results 2/3, then 0/10.
REQ-045 rst asserted mid-WAIT -> outputs zero asynchronously, div_start_o=0, and no whilo_o after release.
